// File: rtl/fir_pkg.sv
// Shared constants and types for the serial 128-tap FIR engine.
package fir_pkg;

    localparam int TAPS      = 128;
    localparam int ADDR_W    = 7;
    localparam int ROM_W     = 64;
    localparam int DRAIN_CYC = 3;

    localparam int SAMPLE_W_DEF = 16;
    localparam int COEF_W_DEF   = 24;
    localparam int ACC_W_DEF    = 48;
    localparam int OUT_W_DEF    = 32;
    localparam int SHIFT_DEF    = 0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } state_t;

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample history: one write port at the write pointer, one
// registered read port addressed as an offset back from the write pointer.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                clka,
    input  logic                rsta_n,
    input  logic                wr_en,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                advance,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_off,
    output logic [SAMPLE_W-1:0] rd_data
);

    logic [SAMPLE_W-1:0] mem [TAPS];
    logic [ADDR_W-1:0]   wp;
    logic [ADDR_W-1:0]   rd_idx;

    // Read index wraps naturally in ADDR_W bits.
    assign rd_idx = wp - rd_off;

    // Write pointer moves on once per completed output.
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            wp <= '0;
        end else if (advance) begin
            wp <= wp + ADDR_W'(1);
        end
    end

    // Sample storage; cleared on reset so a restarted filter sees silence.
    // NOTE: this array is built from flops rather than RAM because it must reset to zero.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            for (int i = 0; i < TAPS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wp] <= wr_data;
        end
    end

    // Registered read port, launched in step with the ROM address register.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/fir_mac_engine.sv
// Serial 128-tap FIR: accepts one sample, sweeps coefficient ROM addresses
// 0..127, multiply-accumulates against the delayed samples, and presents the
// scaled result on a valid/ready output.
// Build option: define FIR_SAT_EN to saturate the output instead of wrapping.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int COEF_W   = COEF_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int SHIFT    = SHIFT_DEF
) (
    input  logic                clka,
    input  logic                rsta_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [ROM_W-1:0]    rom_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data
);

    localparam int PROD_W = SAMPLE_W + COEF_W;

    state_t                     state;
    state_t                     state_next;
    logic [ADDR_W-1:0]          k;
    logic                       accept;
    logic                       last_tap;
    logic                       drain_done;
    logic                       v_addr;
    logic                       v_data;
    logic                       v_prod;
    logic [SAMPLE_W-1:0]        rd_sample;
    logic signed [SAMPLE_W-1:0] sample_al;
    logic signed [COEF_W-1:0]   coef;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    acc_shift;
    logic [OUT_W-1:0]           scaled;
    logic                       unused_bits;

    assign accept     = (state == IDLE) && in_valid;
    assign last_tap   = (state == RUN) && (k == ADDR_W'(TAPS - 1));
    assign drain_done = (state == DRAIN) && (k == ADDR_W'(DRAIN_CYC - 1));
    assign coef       = rom_data[COEF_W-1:0];

    // State register.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (in_valid)   state_next = RUN;
            RUN:   if (last_tap)   state_next = DRAIN;
            DRAIN: if (drain_done) state_next = OUT;
            OUT:   if (out_ready)  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
    end

    // Tap counter in RUN, reused as the drain cycle counter in DRAIN.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            k <= '0;
        end else if (accept || drain_done) begin
            k <= '0;
        end else if (state == RUN || state == DRAIN) begin
            k <= k + ADDR_W'(1);
        end
    end

    // ROM address register: shows tap k the cycle after it is issued.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            rom_addr <= '0;
        end else if (state == RUN) begin
            rom_addr <= k;
        end
    end

    fir_delay_line #(
        .SAMPLE_W (SAMPLE_W)
    ) u_delay (
        .clka    (clka),
        .rsta_n  (rsta_n),
        .wr_en   (accept),
        .wr_data (in_data),
        .advance (drain_done),
        .rd_en   (state == RUN),
        .rd_off  (k),
        .rd_data (rd_sample)
    );

    // MAC pipeline: align the sample with ROM data, register the product,
    // with a valid bit travelling alongside each stage.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            v_addr    <= 1'b0;
            v_data    <= 1'b0;
            v_prod    <= 1'b0;
            sample_al <= '0;
            prod      <= '0;
        end else begin
            v_addr    <= (state == RUN);
            v_data    <= v_addr;
            v_prod    <= v_data;
            sample_al <= $signed(rd_sample);
            prod      <= PROD_W'(sample_al) * PROD_W'(coef);
        end
    end

    // Accumulate the sign-extended product when it carries a real tap.
    always_comb begin
        acc_next = acc;
        if (v_prod) begin
            acc_next = acc + ACC_W'(prod);
        end
    end

    // Accumulator register, cleared when a new sample is taken.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Shift then clamp into the signed output range.
    always_comb begin
        acc_shift = acc_next >>> SHIFT;
        scaled    = acc_shift[OUT_W-1:0];
        if (acc_shift > SAT_MAX) begin
            scaled = SAT_MAX[OUT_W-1:0];
        end else if (acc_shift < SAT_MIN) begin
            scaled = SAT_MIN[OUT_W-1:0];
        end
    end

    assign unused_bits = ^rom_data[ROM_W-1:COEF_W];
`else
    // Shift then keep the low bits (two's-complement wrap).
    always_comb begin
        acc_shift = acc_next >>> SHIFT;
        scaled    = acc_shift[OUT_W-1:0];
    end

    assign unused_bits = ^{rom_data[ROM_W-1:COEF_W], acc_shift[ACC_W-1:OUT_W]};
`endif

    // Output register: loaded with the final sum as DRAIN ends, held through OUT.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            out_data <= '0;
        end else if (drain_done) begin
            out_data <= scaled;
        end
    end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: models the coefficient ROM,
// keeps its own sample history and pushes expected outputs to a scoreboard.
module tb_fir_mac_engine;

    localparam int SHIFT = 0;

    logic        clka;
    logic        rsta_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [6:0]  rom_addr;
    logic [63:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks   = 0;
    int failures = 0;

    logic signed [31:0] sb[$];
    int                 hist[128];
    int                 mwp;
    longint             outs[129];

    fir_mac_engine dut (
        .clka      (clka),
        .rsta_n    (rsta_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    function automatic int coef(input int a);
        case (a)
            0:       return 0;
            1:       return 456122;
            2:       return 849611;
            3:       return 1127499;
            default: return ((a * 7919) % 1600001) - 800000;
        endcase
    endfunction

    // Registered coefficient ROM with junk in the unused upper bits.
    always @(posedge clka) begin : rom_model
        int c;
        c = coef(int'(rom_addr));
        rom_data <= {40'hA5C396E10F ^ {33'd0, rom_addr}, c[23:0]};
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] model_out(input int p);
        longint acc = 0;
        for (int t = 0; t < 128; t++) begin
            acc += longint'(coef(t)) * longint'(hist[(p - t + 128) % 128]);
        end
        acc = acc >>> SHIFT;
`ifdef FIR_SAT_EN
        if (acc > 64'sd2147483647) acc = 64'sd2147483647;
        if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`endif
        return acc[31:0];
    endfunction

    function automatic void model_push(input int x);
        hist[mwp] = x;
        sb.push_back(model_out(mwp));
        mwp = (mwp + 1) % 128;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 128; i++) hist[i] = 0;
        mwp = 0;
        sb.delete();
    endfunction

    task automatic send(input int x);
        int n = 0;
        @(negedge clka);
        in_valid = 1'b1;
        in_data  = x[15:0];
        while (!in_ready && n < 400) begin
            @(negedge clka);
            n++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clka);
        model_push(x);
        #1 in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, output longint got);
        int n = 0;
        logic signed [31:0] e;
        @(negedge clka);
        while (!out_valid && n < 300) begin
            @(negedge clka);
            n++;
        end
        if (!out_valid) check({tag, "_timeout"}, out_valid, 1);
        got = longint'($signed(out_data));
        e = 32'sd0;
        if (sb.size() > 0) e = sb.pop_front();
        check(tag, got, longint'(e));
        @(posedge clka);
        #1;
    endtask

    task automatic run_impulse(input string tag, input int amp, input int nz);
        collect_one(tag, amp, 0);
        for (int i = 1; i <= nz; i++) collect_one(tag, 0, i);
    endtask

    task automatic collect_one(input string tag, input int x, input int idx);
        longint got;
        send(x);
        collect(tag, got);
        outs[idx] = got;
    endtask

    task automatic do_reset();
        @(negedge clka);
        rsta_n = 1'b0;
        @(negedge clka);
        @(negedge clka);
        rsta_n = 1'b1;
        model_reset();
    endtask

    task automatic check_impulse_literals(input string tag);
        check({tag, "_c0"}, outs[0], 0);
        check({tag, "_c1"}, outs[1], 456122);
        check({tag, "_c2"}, outs[2], 849611);
        check({tag, "_c3"}, outs[3], 1127499);
        check({tag, "_129th"}, outs[128], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     bad;
        int     n;
        longint got;
        logic signed [31:0] e;

        rsta_n    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset values.
        #3 rsta_n = 1'b0;
        repeat (3) @(negedge clka);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_rom_addr", rom_addr, 0);
        rsta_n = 1'b1;

        // Latency and address sweep on the first impulse sample.
        out_ready = 1'b1;
        @(negedge clka);
        in_valid = 1'b1;
        in_data  = 16'sd1;
        check("idle_in_ready", in_ready, 1);
        @(posedge clka);
        model_push(1);
        #1 in_valid = 1'b0;
        bad = 0;
        for (int t = 0; t < 128; t++) begin
            @(posedge clka);
            @(negedge clka);
            check($sformatf("rom_addr_%0d", t), rom_addr, t);
            if (in_ready || out_valid) bad++;
        end
        check("busy_flags_in_run", bad, 0);
        repeat (2) begin
            @(posedge clka);
            @(negedge clka);
        end
        check("no_early_out_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 0);
        @(posedge clka);
        @(negedge clka);
        check("out_valid_e131", out_valid, 1);
        got = longint'($signed(out_data));
        e = sb.pop_front();
        check("impulse_first", got, longint'(e));
        outs[0] = got;
        @(posedge clka);
        @(negedge clka);
        check("in_ready_e132", in_ready, 1);
        check("out_valid_e132", out_valid, 0);

        // Rest of the impulse response.
        for (int i = 1; i <= 128; i++) collect_one("impulse", 0, i);
        check_impulse_literals("impulse");

        // Backpressure: result held, incoming sample refused until handshake.
        out_ready = 1'b0;
        send(300);
        n = 0;
        @(negedge clka);
        while (!out_valid && n < 300) begin
            @(negedge clka);
            n++;
        end
        check("bp_out_valid", out_valid, 1);
        in_valid = 1'b1;
        in_data  = -16'sd7;
        e = sb.pop_front();
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clka);
            check("bp_hold_data", longint'($signed(out_data)), longint'(e));
            if (in_ready || !out_valid) bad++;
        end
        check("bp_flags", bad, 0);
        out_ready = 1'b1;
        @(posedge clka);
        @(negedge clka);
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        @(posedge clka);
        model_push(-7);
        #1 in_valid = 1'b0;
        collect("bp_next", got);

        // Reset mid-RUN, then the impulse must match a clean start.
        send(12345);
        n = 0;
        while (rom_addr != 7'd50 && n < 200) begin
            @(negedge clka);
            n++;
        end
        check("mid_run_tap", rom_addr, 50);
        #2 rsta_n = 1'b0;
        #1;
        check("mid_rst_rom_addr", rom_addr, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_data", out_data, 0);
        @(negedge clka);
        @(negedge clka);
        rsta_n = 1'b1;
        model_reset();
        run_impulse("re_impulse", 1, 128);
        check_impulse_literals("re_impulse");

        // Overflow: large positive and negative impulses.
        do_reset();
        run_impulse("ovf_pos", 32767, 1);
        check("ovf_pos_first", outs[0], 0);
`ifdef FIR_SAT_EN
        check("ovf_pos_second", outs[1], 2147483647);
`else
        check("ovf_pos_second", outs[1], 2060847686);
`endif
        do_reset();
        run_impulse("ovf_neg", -32768, 1);
        check("ovf_neg_first", outs[0], 0);
`ifdef FIR_SAT_EN
        check("ovf_neg_second", outs[1], -64'sd2147483648);
`else
        check("ovf_neg_second", outs[1], -2061303808);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
